// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding and fetch-stage defaults.
package cpu_pkg;

  localparam int unsigned CPU_ADDR_W    = 32;
  localparam logic [15:0] CPU_NOP_INSTR = 16'hBF00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of {pc, instr} entries; clear beats push and pop.
module fetch_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 48
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear_i,
  input  logic                         push_i,
  input  logic [DATA_W-1:0]            wdata_i,
  input  logic                         pop_i,
  output logic [DATA_W-1:0]            rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH):0]       count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == {CNT_W{1'b0}});
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding imem reader, prefetch FIFO and
// the IR/PC register presented to ID, with branch flush and redirect.
module fetch_stage #(
  parameter int unsigned       ADDR_W     = cpu_pkg::CPU_ADDR_W,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = {ADDR_W{1'b0}},
  parameter logic [15:0]       NOP_INSTR  = cpu_pkg::CPU_NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_stall_id,
  input  logic              i_branch_met,
  input  logic [ADDR_W-1:0] i_branch_target,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_gnt,
  input  logic              i_imem_valid,
  input  logic [15:0]       i_imem_rdata,
  output logic [15:0]       o_ir_id,
  output logic [ADDR_W-1:0] o_pc_id,
  output logic              o_ir_valid
);
  import cpu_pkg::*;

  localparam int unsigned      CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] target_s;
  logic [15:0]       ir_q, ir_d;
  logic [ADDR_W-1:0] pc_id_q, pc_id_d;
  logic              ir_valid_q, ir_valid_d;
  logic              fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s;
  logic [CNT_W-1:0]  fifo_count_s, count_after_s;
  logic [ADDR_W+15:0] fifo_head_s;

  assign target_s      = {i_branch_target[ADDR_W-1:1], 1'b0};
  assign fifo_pop_s    = !i_branch_met && !i_stall_id && !fifo_empty_s;
  assign count_after_s = fifo_count_s + CNT_W'(1) - CNT_W'(fifo_pop_s);

  fetch_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (ADDR_W + 16)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (i_branch_met),
    .push_i  (fifo_push_s),
    .wdata_i ({fetch_pc_q - ADDR_W'(2), i_imem_rdata}),
    .pop_i   (fifo_pop_s),
    .rdata_o (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  // Fetch FSM; a granted request already advanced fetch_pc, so the
  // returning halfword belongs to fetch_pc-2.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    fifo_push_s = 1'b0;
    if (i_branch_met) begin
      fetch_pc_d = target_s;
      case (state_q)
        REQ:     state_d = i_imem_gnt   ? DROP : REQ;
        WAIT:    state_d = i_imem_valid ? REQ  : DROP;
        DROP:    state_d = i_imem_valid ? REQ  : DROP;
        default: state_d = REQ;
      endcase
    end else begin
      case (state_q)
        IDLE: state_d = fifo_full_s ? IDLE : REQ;
        REQ: begin
          if (i_imem_gnt) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(2);
            state_d    = WAIT;
          end else begin
            state_d = REQ;
          end
        end
        WAIT: begin
          if (i_imem_valid) begin
            fifo_push_s = 1'b1;
            state_d     = (count_after_s == DEPTH_C) ? IDLE : REQ;
          end else begin
            state_d = WAIT;
          end
        end
        DROP:    state_d = i_imem_valid ? REQ : DROP;
        default: state_d = IDLE;
      endcase
    end
  end

  // ID register: flush beats stall, stall holds, otherwise pop or bubble.
  always_comb begin
    ir_d       = ir_q;
    pc_id_d    = pc_id_q;
    ir_valid_d = ir_valid_q;
    if (i_branch_met) begin
      ir_d       = NOP_INSTR;
      ir_valid_d = 1'b0;
    end else if (i_stall_id) begin
      ir_d       = ir_q;
      ir_valid_d = ir_valid_q;
    end else if (!fifo_empty_s) begin
      ir_d       = fifo_head_s[15:0];
      pc_id_d    = fifo_head_s[ADDR_W+15:16];
      ir_valid_d = 1'b1;
    end else begin
      ir_d       = NOP_INSTR;
      ir_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      ir_q       <= NOP_INSTR;
      pc_id_q    <= RESET_PC;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      ir_q       <= ir_d;
      pc_id_q    <= pc_id_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign o_imem_req  = (state_q == REQ);
  assign o_imem_addr = fetch_pc_q;
  assign o_ir_id     = ir_q;
  assign o_pc_id     = pc_id_q;
  assign o_ir_valid  = ir_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed table, corner-case sequences
// and a randomized run against a program-order instruction-stream model.
module tb_fetch_stage;

  localparam logic [15:0] NOP = 16'hBF00;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_stall_id, i_branch_met;
  logic [31:0] i_branch_target;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt, i_imem_valid;
  logic [15:0] i_imem_rdata;
  logic [15:0] o_ir_id;
  logic [31:0] o_pc_id;
  logic        o_ir_valid;

  always #5 clk = ~clk;

  fetch_stage #(
    .ADDR_W(32), .FIFO_DEPTH(4), .RESET_PC(32'h0), .NOP_INSTR(16'hBF00)
  ) dut (
    .clk(clk), .rst(rst), .i_stall_id(i_stall_id), .i_branch_met(i_branch_met),
    .i_branch_target(i_branch_target), .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_gnt(i_imem_gnt), .i_imem_valid(i_imem_valid), .i_imem_rdata(i_imem_rdata),
    .o_ir_id(o_ir_id), .o_pc_id(o_pc_id), .o_ir_valid(o_ir_valid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Memory responder settings and its single outstanding read.
  int          gnt_pct = 100, lat_min = 0, lat_max = 0;
  logic        pend;
  logic [31:0] pend_addr;
  int          pend_dly;

  // Architectural model: next fetch address, next expected delivered pc,
  // and the ID register contents last seen.
  logic [31:0] m_fetch, m_next, m_pc;
  logic [15:0] m_ir;
  logic        m_valid, m_pc_known;
  int          deliveries;

  typedef struct {
    logic        stall;
    logic        flush;
    logic [31:0] tgt;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_v;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t tbl [8];

  function automatic logic [15:0] code(input logic [31:0] a);
    return a[16:1] ^ a[31:16] ^ 16'h3C5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fetch = 32'h0; m_next = 32'h0; m_pc = 32'h0; m_ir = NOP;
    m_valid = 1'b0; m_pc_known = 1'b1; pend = 1'b0; pend_dly = 0;
  endtask

  // Called at a negedge; one reset edge, check reset outputs, release.
  task automatic do_reset();
    rst = 1'b1; i_stall_id = 1'b0; i_branch_met = 1'b0; i_branch_target = 32'h0;
    i_imem_gnt = 1'b0; i_imem_valid = 1'b0; i_imem_rdata = 16'h0;
    @(posedge clk); #1;
    chk("reset_req",   32'(o_imem_req), 32'h0);
    chk("reset_ir",    32'(o_ir_id),    32'(NOP));
    chk("reset_valid", 32'(o_ir_valid), 32'h0);
    chk("reset_pc_id", o_pc_id,         32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One clock: drive at negedge, let the edge happen, check against the model.
  task automatic cycle(input logic stall, input logic flush, input logic [31:0] tgt);
    logic        p_req, p_gnt, p_valid;
    logic [31:0] p_addr;
    i_stall_id = stall; i_branch_met = flush; i_branch_target = tgt;
    p_req   = o_imem_req;
    p_addr  = o_imem_addr;
    p_gnt   = p_req && ($urandom_range(99, 0) < 32'(gnt_pct));
    p_valid = pend && (pend_dly == 0);
    i_imem_gnt   = p_gnt;
    i_imem_valid = p_valid;
    i_imem_rdata = p_valid ? code(pend_addr) : 16'($urandom);
    if (p_req) begin
      chk("no_outstanding", 32'(pend), 32'h0);
      chk("req_addr", p_addr, m_fetch);
    end
    @(posedge clk); #1;
    if (p_valid) pend = 1'b0;
    else if (pend && pend_dly > 0) pend_dly--;
    if (p_gnt) begin
      pend = 1'b1; pend_addr = p_addr;
      pend_dly = int'($urandom_range(lat_max, lat_min));
      m_fetch = m_fetch + 32'd2;
    end
    if (flush) begin
      m_fetch = tgt & 32'hFFFF_FFFE;
      m_next  = tgt & 32'hFFFF_FFFE;
      chk("flush_ir", 32'(o_ir_id), 32'(NOP));
      chk("flush_valid", 32'(o_ir_valid), 32'h0);
      m_ir = NOP; m_valid = 1'b0; m_pc_known = 1'b0;
    end else if (stall) begin
      chk("stall_hold_ir", 32'(o_ir_id), 32'(m_ir));
      chk("stall_hold_valid", 32'(o_ir_valid), 32'(m_valid));
      if (m_pc_known) chk("stall_hold_pc", o_pc_id, m_pc);
    end else if (o_ir_valid) begin
      chk("stream_pc", o_pc_id, m_next);
      chk("stream_ir", 32'(o_ir_id), 32'(code(m_next)));
      m_pc = m_next; m_ir = code(m_next); m_valid = 1'b1; m_pc_known = 1'b1;
      m_next = m_next + 32'd2;
      deliveries++;
    end else begin
      chk("bubble_ir", 32'(o_ir_id), 32'(NOP));
      if (m_pc_known) chk("bubble_pc", o_pc_id, m_pc);
      m_ir = NOP; m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic run_until_valid(input string name, input int limit);
    int k = 0;
    while (!o_ir_valid && k < limit) begin
      cycle(1'b0, 1'b0, 32'h0);
      k++;
    end
    chk({name, "_timeout"}, 32'(o_ir_valid), 32'h1);
  endtask

  task automatic run_until_grant(input string name, input int limit);
    int k = 0;
    while (!pend && k < limit) begin
      cycle(1'b0, 1'b0, 32'h0);
      k++;
    end
    chk({name, "_timeout"}, 32'(pend), 32'h1);
  endtask

  initial begin
    int          k;
    logic        s, f;
    logic [31:0] t;

    // Reset then gnt same cycle / valid one cycle later: one instr per 2 cycles.
    tbl[0] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    tbl[2] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h2, 1'b0, 32'h0};
    tbl[3] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0};
    tbl[4] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h4, 1'b0, 32'h0};
    tbl[5] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h2};
    tbl[6] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h6, 1'b0, 32'h2};
    tbl[7] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h4};

    deliveries = 0;
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].stall, tbl[i].flush, tbl[i].tgt);
      chk($sformatf("t1_req[%0d]", i), 32'(o_imem_req), 32'(tbl[i].exp_req));
      if (tbl[i].exp_req) chk($sformatf("t1_addr[%0d]", i), o_imem_addr, tbl[i].exp_addr);
      chk($sformatf("t1_valid[%0d]", i), 32'(o_ir_valid), 32'(tbl[i].exp_v));
      chk($sformatf("t1_pc[%0d]", i), o_pc_id, tbl[i].exp_pc);
      chk($sformatf("t1_ir[%0d]", i), 32'(o_ir_id),
          32'(tbl[i].exp_v ? code(tbl[i].exp_pc) : NOP));
    end

    // Stall for 10 cycles: IR held, FIFO fills, requests stop; then drains.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      chk("t2_hold_pc", o_pc_id, 32'h4);
    end
    chk("t2_req_stopped", 32'(o_imem_req), 32'h0);
    for (int j = 0; j < 4; j++) begin
      cycle(1'b0, 1'b0, 32'h0);
      chk($sformatf("t2_drain_valid[%0d]", j), 32'(o_ir_valid), 32'h1);
      chk($sformatf("t2_drain_pc[%0d]", j), o_pc_id, 32'h6 + 32'(2 * j));
    end

    // Branch to 0x100 while waiting on a slow response.
    lat_min = 2; lat_max = 2;
    run_until_grant("t3_grant", 20);
    cycle(1'b0, 1'b1, 32'h100);
    chk("t3_flush_valid", 32'(o_ir_valid), 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    chk("t3_req", 32'(o_imem_req), 32'h1);
    chk("t3_addr", o_imem_addr, 32'h100);
    lat_min = 0; lat_max = 0;
    run_until_valid("t3_first", 20);
    chk("t3_first_pc", o_pc_id, 32'h100);

    // Flush in REQ without grant: address retargets, request stays up.
    gnt_pct = 0;
    k = 0;
    while (!o_imem_req && k < 20) begin
      cycle(1'b0, 1'b0, 32'h0);
      k++;
    end
    chk("t4_req_timeout", 32'(o_imem_req), 32'h1);
    cycle(1'b0, 1'b1, 32'h41);
    chk("t4_req", 32'(o_imem_req), 32'h1);
    chk("t4_addr", o_imem_addr, 32'h40);
    gnt_pct = 100;

    // Flush with stall on a filled FIFO.
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h200);
    chk("t5_ir", 32'(o_ir_id), 32'(NOP));
    chk("t5_valid", 32'(o_ir_valid), 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    chk("t5_fifo_empty", 32'(o_ir_valid), 32'h0);
    run_until_valid("t5_first", 20);
    chk("t5_first_pc", o_pc_id, 32'h200);

    // Wrap of the PC, then reset while a read is outstanding.
    cycle(1'b0, 1'b1, 32'hFFFF_FFFE);
    run_until_valid("t6_wrap_a", 20);
    chk("t6_pc_a", o_pc_id, 32'hFFFF_FFFE);
    cycle(1'b0, 1'b0, 32'h0);
    run_until_valid("t6_wrap_b", 20);
    chk("t6_pc_b", o_pc_id, 32'h0);
    lat_min = 2; lat_max = 2;
    run_until_grant("t6_grant", 20);
    do_reset();
    lat_min = 0; lat_max = 0;
    run_until_valid("t6_after_reset", 20);
    chk("t6_after_reset_pc", o_pc_id, 32'h0);

    // Randomized traffic against the stream model.
    gnt_pct = 60; lat_min = 0; lat_max = 3;
    deliveries = 0;
    for (int i = 0; i < 1500; i++) begin
      s = ($urandom_range(3, 0) == 0);
      f = ($urandom_range(19, 0) == 0);
      t = $urandom;
      if ($urandom_range(3, 0) == 0) t = 32'hFFFF_FFF8 | (t & 32'h7);
      cycle(s, f, t);
    end
    chk("random_liveness", 32'(deliveries >= 50), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
